// File: rtl/hazard_stall_controller_if.sv
// Bundle of decode, EX, MEM and control signals around the hazard/stall controller.
// The pipeline side uses the master modport. The controller uses the slave modport.
interface hazard_stall_controller_if;
  // decode stage
  logic [4:0]  id_rs_num;
  logic [4:0]  id_src2_num;
  logic        id_complex;
  logic [3:0]  id_rs1_c;
  logic [3:0]  id_rs2_c;
  logic [3:0]  id_src3_c;
  logic [3:0]  id_src4_c;
  logic        id_flow_change;
  logic        id_halted;
  // execute stage
  logic        ex_is_load;
  logic        ex_reg_write_en;
  logic [4:0]  ex_write_register;
  logic        ex_complex;
  logic [3:0]  ex_write_c;
  logic [3:0]  ex_write_c2;
  // memory stage / cache
  logic        mem_cache_en;
  logic        mem_ready;
  // controls back to the pipeline
  logic        is_hazard_detected;
  logic        pc_write_en;
  logic        if_id_write_en;
  logic        if_id_flush;
  logic        id_ex_bubble;
  logic        pipe_freeze;
  logic        halted_out;
  logic        mem_timeout_err;
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;

  modport master (
    output id_rs_num, id_src2_num, id_complex, id_rs1_c, id_rs2_c, id_src3_c, id_src4_c,
           id_flow_change, id_halted, ex_is_load, ex_reg_write_en, ex_write_register,
           ex_complex, ex_write_c, ex_write_c2, mem_cache_en, mem_ready,
    input  is_hazard_detected, pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           pipe_freeze, halted_out, mem_timeout_err, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs_num, id_src2_num, id_complex, id_rs1_c, id_rs2_c, id_src3_c, id_src4_c,
           id_flow_change, id_halted, ex_is_load, ex_reg_write_en, ex_write_register,
           ex_complex, ex_write_c, ex_write_c2, mem_cache_en, mem_ready,
    output is_hazard_detected, pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble,
           pipe_freeze, halted_out, mem_timeout_err, stall_cycles, flush_count
  );
endinterface

// File: rtl/hazard_stall_controller.sv
// Hazard and stall sequencer for the IF/ID/EX pipeline.
// It detects load-use hazards, freezes the pipeline on cache misses,
// flushes IF/ID on redirects and holds a sticky halt.
// Optional macro HAZARD_PERF_CNT_EN enables the stall_cycles and flush_count counters.
// When the macro is undefined, both counters read 0 and no counter flops exist.
module hazard_stall_controller #(
  parameter int LOAD_USE_CYCLES = 1,   // bubbles per load-use hazard (1..15)
  parameter int MEM_TIMEOUT     = 255  // MEM_WAIT cycles before timeout error (1..255)
) (
  input logic                      clk,
  input logic                      rst_n,
  hazard_stall_controller_if.slave bus
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, MEM_WAIT, HALT} state_t;

  localparam logic [3:0] LOAD_INIT = 4'(LOAD_USE_CYCLES - 1);
  localparam logic [7:0] TIMEOUT   = 8'(MEM_TIMEOUT);

  state_t     state_reg, state_next;
  logic [3:0] load_cnt_reg, load_cnt_next;   // remaining bubbles, kept across a MEM_WAIT
  logic [7:0] wait_cnt_reg, wait_cnt_next;   // MEM_WAIT cycle index, saturating
  logic       err_reg, err_next;

  logic is_hazard_detected, pc_write_en, if_id_write_en;
  logic if_id_flush, id_ex_bubble, pipe_freeze;

  logic mem_miss;
  logic scalar_hit;
  logic complex_hit;
  logic load_use_hit;

  // Complex sources: rs1/rs2 are always compared, src3/src4 only when nonzero.
  logic [3:0] c_src [4];
  logic [3:0] c_match;

  assign c_src[0] = bus.id_rs1_c;
  assign c_src[1] = bus.id_rs2_c;
  assign c_src[2] = bus.id_src3_c;
  assign c_src[3] = bus.id_src4_c;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cmatch
      localparam bit ALWAYS_USED = (gi < 2);
      assign c_match[gi] = (ALWAYS_USED || (c_src[gi] != 4'd0)) &&
                           ((c_src[gi] == bus.ex_write_c) || (c_src[gi] == bus.ex_write_c2));
    end
  endgenerate

  assign mem_miss    = bus.mem_cache_en && !bus.mem_ready;
  assign scalar_hit  = !bus.ex_complex && !bus.id_complex &&
                       (bus.ex_write_register != 5'd0) &&
                       ((bus.ex_write_register == bus.id_rs_num) ||
                        (bus.ex_write_register == bus.id_src2_num));
  assign complex_hit = bus.ex_complex && bus.id_complex && (|c_match);
  assign load_use_hit = bus.ex_is_load && bus.ex_reg_write_en && (scalar_hit || complex_hit);

  // State, counters and sticky timeout error. Reset is asynchronous.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= RUN;
      load_cnt_reg <= 4'd0;
      wait_cnt_reg <= 8'd0;
      err_reg      <= 1'b0;
    end else begin
      state_reg    <= state_next;
      load_cnt_reg <= load_cnt_next;
      wait_cnt_reg <= wait_cnt_next;
      err_reg      <= err_next;
    end
  end

  // Next-state and pipeline controls. A miss always wins over hazards. Redirect and halt only act in RUN.
  always_comb begin
    state_next         = state_reg;
    load_cnt_next      = load_cnt_reg;
    wait_cnt_next      = wait_cnt_reg;
    is_hazard_detected = 1'b0;
    pc_write_en        = 1'b1;
    if_id_write_en     = 1'b1;
    if_id_flush        = 1'b0;
    id_ex_bubble       = 1'b0;
    pipe_freeze        = 1'b0;

    unique case (state_reg)
      RUN: begin
        if (mem_miss) begin
          pipe_freeze    = 1'b1;
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          state_next     = MEM_WAIT;
          wait_cnt_next  = 8'd1;
          load_cnt_next  = 4'd0;
        end else if (load_use_hit) begin
          is_hazard_detected = 1'b1;
          id_ex_bubble       = 1'b1;
          pc_write_en        = 1'b0;
          if_id_write_en     = 1'b0;
          if (LOAD_USE_CYCLES > 1) begin
            state_next    = LOAD_STALL;
            load_cnt_next = LOAD_INIT;
          end
        end else if (bus.id_flow_change) begin
          if_id_flush = 1'b1;
        end else if (bus.id_halted) begin
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          state_next     = HALT;
        end
      end

      LOAD_STALL: begin
        if (mem_miss) begin
          // The load count is left untouched so the bubbles resume after the miss.
          pipe_freeze    = 1'b1;
          pc_write_en    = 1'b0;
          if_id_write_en = 1'b0;
          state_next     = MEM_WAIT;
          wait_cnt_next  = 8'd1;
        end else begin
          is_hazard_detected = 1'b1;
          id_ex_bubble       = 1'b1;
          pc_write_en        = 1'b0;
          if_id_write_en     = 1'b0;
          if (load_cnt_reg <= 4'd1) begin
            state_next    = RUN;
            load_cnt_next = 4'd0;
          end else begin
            load_cnt_next = load_cnt_reg - 4'd1;
          end
        end
      end

      MEM_WAIT: begin
        // The freeze drops in the completion cycle. PC and IF/ID stay held until the next state.
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        if (bus.mem_ready) begin
          state_next = (load_cnt_reg != 4'd0) ? LOAD_STALL : RUN;
        end else begin
          pipe_freeze = 1'b1;
          if (wait_cnt_reg < TIMEOUT) begin
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end
      end

      HALT: begin
        pc_write_en    = 1'b0;
        if_id_write_en = 1'b0;
        id_ex_bubble   = 1'b1;
      end

      default: state_next = RUN;
    endcase

    err_next = err_reg || ((state_next == MEM_WAIT) && (wait_cnt_next >= TIMEOUT));
  end

  assign bus.is_hazard_detected = is_hazard_detected;
  assign bus.pc_write_en        = pc_write_en;
  assign bus.if_id_write_en     = if_id_write_en;
  assign bus.if_id_flush        = if_id_flush;
  assign bus.id_ex_bubble       = id_ex_bubble;
  assign bus.pipe_freeze        = pipe_freeze;
  assign bus.halted_out         = (state_reg == HALT);
  assign bus.mem_timeout_err    = err_reg;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_count_reg;

  // Wrapping counters: stalled cycles outside HALT, and IF/ID flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_reg <= 32'd0;
      flush_count_reg  <= 32'd0;
    end else begin
      if (!pc_write_en && (state_reg != HALT)) begin
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      end
      if (if_id_flush) begin
        flush_count_reg <= flush_count_reg + 32'd1;
      end
    end
  end

  assign bus.stall_cycles = stall_cycles_reg;
  assign bus.flush_count  = flush_count_reg;
`else
  assign bus.stall_cycles = 32'd0;
  assign bus.flush_count  = 32'd0;
`endif

endmodule
